// File: rtl/minn_pkg.sv
// Shared types and helpers for the Minn training-symbol transmit path.
package minn_pkg;

    typedef enum logic [1:0] {IDLE, CP, PRE, PAYLOAD} state_t;

    // Bit q set means quarter q of the symbol carries -A instead of A.
    localparam logic [3:0] QUARTER_SIGN = 4'b1100;

    function automatic int sat_neg(input int x, input int width);
        int lim;
        lim = 1 << (width - 1);
        return (x == -lim) ? lim - 1 : -x;
    endfunction

endpackage

// File: rtl/minn_preamble_inserter_if.sv
// Two-channel I/Q sample stream with valid/ready handshake.
interface minn_preamble_inserter_if #(
    parameter int SAMPLE_WIDTH = 12
);
    logic                           valid;
    logic                           ready;
    logic signed [SAMPLE_WIDTH-1:0] ch0_i;
    logic signed [SAMPLE_WIDTH-1:0] ch0_q;
    logic signed [SAMPLE_WIDTH-1:0] ch1_i;
    logic signed [SAMPLE_WIDTH-1:0] ch1_q;

    modport master (output valid, ch0_i, ch0_q, ch1_i, ch1_q, input ready);
    modport slave  (input valid, ch0_i, ch0_q, ch1_i, ch1_q, output ready);
endinterface

// File: rtl/minn_quarter_ram.sv
// Quarter-sequence store: one write port, one registered read port with enable.
module minn_quarter_ram #(
    parameter int DEPTH = 512,
    parameter int WIDTH = 24
) (
    input  logic                     clk,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output logic [WIDTH-1:0]         rd_data_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
        if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;
endmodule

// File: rtl/minn_preamble_inserter.sv
// Emits one Minn training symbol (CP + [A A -A -A]) on request, then forwards a fixed payload.
module minn_preamble_inserter
    import minn_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 12,
    parameter int NFFT         = 2048,
    parameter int CP_LEN       = 512,
    parameter int PAYLOAD_LEN  = 8192
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          seq_wr_en_i,
    input  logic [$clog2(NFFT/4)-1:0]     seq_wr_addr_i,
    input  logic [SAMPLE_WIDTH-1:0]       seq_wr_i_i,
    input  logic [SAMPLE_WIDTH-1:0]       seq_wr_q_i,
    input  logic                          frame_req_i,
    output logic                          busy_o,
    minn_preamble_inserter_if.slave       in_s,
    minn_preamble_inserter_if.master      out_m,
    output logic                          frame_start_o,
    output logic                          payload_start_o,
    output logic                          frame_done_o
);
    localparam int W  = SAMPLE_WIDTH;
    localparam int QW = $clog2(NFFT/4);
    localparam int SW = $clog2(NFFT);
    localparam int PW = $clog2(PAYLOAD_LEN + 2);
    localparam logic [SW-1:0] S_CP_FIRST = SW'(NFFT - CP_LEN);
    localparam logic [SW-1:0] S_LAST     = SW'(NFFT - 1);

    state_t state_q, state_d;
    logic          busy_q, busy_d;
    logic [SW-1:0] s_q, s_d;
    logic          first_q, first_d;
    logic          reads_done_q, reads_done_d;
    logic [PW-1:0] rem_q, rem_d;
    logic rd_vld_q, rd_vld_d, rd_neg_q, rd_neg_d, rd_first_q, rd_first_d, rd_last_q, rd_last_d;
    logic out_vld_q, out_vld_d, out_fs_q, out_fs_d, out_ps_q, out_ps_d, out_last_q, out_last_d;
    logic signed [W-1:0] o0i_q, o0i_d, o0q_q, o0q_d, o1i_q, o1i_d, o1q_q, o1q_d;

    logic adv, rd_en, frame_acc, in_rdy, in_hs, out_hs;
    logic [2*W-1:0]      rd_data;
    logic signed [W-1:0] rd_i, rd_q, pre_i, pre_q;

    minn_quarter_ram #(.DEPTH(NFFT/4), .WIDTH(2*W)) u_ram (
        .clk       (clk),
        .wr_en_i   (seq_wr_en_i && (state_q == IDLE)),
        .wr_addr_i (seq_wr_addr_i),
        .wr_data_i ({seq_wr_i_i, seq_wr_q_i}),
        .rd_en_i   (rd_en),
        .rd_addr_i (s_q[QW-1:0]),
        .rd_data_o (rd_data)
    );

    // Pipeline moves only when the output register is free, so stalls freeze every stage.
    assign adv       = !out_vld_q || out_m.ready;
    assign rd_en     = ((state_q == CP) || ((state_q == PRE) && !reads_done_q)) && adv;
    assign frame_acc = (state_q == IDLE) && !busy_q && frame_req_i;
    assign in_rdy    = (state_q == PAYLOAD) && (rem_q != '0) && adv;
    assign in_hs     = in_s.valid && in_rdy;
    assign out_hs    = out_vld_q && out_m.ready;

    assign rd_i  = rd_data[2*W-1:W];
    assign rd_q  = rd_data[W-1:0];
    assign pre_i = rd_neg_q ? W'(sat_neg(int'(rd_i), W)) : rd_i;
    assign pre_q = rd_neg_q ? W'(sat_neg(int'(rd_q), W)) : rd_q;

    always_comb begin
        state_d      = state_q;
        busy_d       = busy_q;
        s_d          = s_q;
        first_d      = first_q;
        reads_done_d = reads_done_q;
        rem_d        = rem_q;
        rd_vld_d     = rd_vld_q;
        rd_neg_d     = rd_neg_q;
        rd_first_d   = rd_first_q;
        rd_last_d    = rd_last_q;
        out_vld_d    = out_vld_q;
        out_fs_d     = out_fs_q;
        out_ps_d     = out_ps_q;
        out_last_d   = out_last_q;
        o0i_d        = o0i_q;
        o0q_d        = o0q_q;
        o1i_d        = o1i_q;
        o1q_d        = o1q_q;

        if (out_hs && out_last_q) busy_d = 1'b0;

        unique case (state_q)
            IDLE: if (frame_acc) begin
                busy_d       = 1'b1;
                first_d      = 1'b1;
                reads_done_d = 1'b0;
                state_d      = (CP_LEN > 0) ? CP : PRE;
                s_d          = (CP_LEN > 0) ? S_CP_FIRST : '0;
            end
            CP: if (rd_en) begin
                s_d     = s_q + SW'(1);
                first_d = 1'b0;
                if (s_q == S_LAST) state_d = PRE;
            end
            PRE: begin
                if (rd_en) begin
                    s_d     = s_q + SW'(1);
                    first_d = 1'b0;
                    if (s_q == S_LAST) reads_done_d = 1'b1;
                end
                // Leave PRE only once the final symbol sample has moved into the output register.
                if (reads_done_q && rd_vld_q && adv) begin
                    if (PAYLOAD_LEN > 0) begin
                        state_d = PAYLOAD;
                        rem_d   = PW'(PAYLOAD_LEN);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            PAYLOAD: if (in_hs) begin
                rem_d = rem_q - PW'(1);
                if (rem_q == PW'(1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (adv) begin
            rd_vld_d   = rd_en;
            rd_neg_d   = QUARTER_SIGN[s_q[SW-1 -: 2]];
            rd_first_d = first_q;
            rd_last_d  = (state_q == PRE) && (s_q == S_LAST) && (PAYLOAD_LEN == 0);

            out_vld_d  = rd_vld_q || in_hs;
            out_fs_d   = 1'b0;
            out_ps_d   = 1'b0;
            out_last_d = 1'b0;
            if (rd_vld_q) begin
                o0i_d      = pre_i;
                o0q_d      = pre_q;
                o1i_d      = pre_i;
                o1q_d      = pre_q;
                out_fs_d   = rd_first_q;
                out_last_d = rd_last_q;
            end else if (in_hs) begin
                o0i_d      = in_s.ch0_i;
                o0q_d      = in_s.ch0_q;
                o1i_d      = in_s.ch1_i;
                o1q_d      = in_s.ch1_q;
                out_ps_d   = (rem_q == PW'(PAYLOAD_LEN));
                out_last_d = (rem_q == PW'(1));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            s_q          <= '0;
            first_q      <= 1'b0;
            reads_done_q <= 1'b0;
            rem_q        <= '0;
            rd_vld_q     <= 1'b0;
            rd_neg_q     <= 1'b0;
            rd_first_q   <= 1'b0;
            rd_last_q    <= 1'b0;
            out_vld_q    <= 1'b0;
            out_fs_q     <= 1'b0;
            out_ps_q     <= 1'b0;
            out_last_q   <= 1'b0;
            o0i_q        <= '0;
            o0q_q        <= '0;
            o1i_q        <= '0;
            o1q_q        <= '0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            s_q          <= s_d;
            first_q      <= first_d;
            reads_done_q <= reads_done_d;
            rem_q        <= rem_d;
            rd_vld_q     <= rd_vld_d;
            rd_neg_q     <= rd_neg_d;
            rd_first_q   <= rd_first_d;
            rd_last_q    <= rd_last_d;
            out_vld_q    <= out_vld_d;
            out_fs_q     <= out_fs_d;
            out_ps_q     <= out_ps_d;
            out_last_q   <= out_last_d;
            o0i_q        <= o0i_d;
            o0q_q        <= o0q_d;
            o1i_q        <= o1i_d;
            o1q_q        <= o1q_d;
        end
    end

    assign in_s.ready      = in_rdy;
    assign out_m.valid     = out_vld_q;
    assign out_m.ch0_i     = o0i_q;
    assign out_m.ch0_q     = o0q_q;
    assign out_m.ch1_i     = o1i_q;
    assign out_m.ch1_q     = o1q_q;
    assign busy_o          = busy_q;
    assign frame_start_o   = out_fs_q;
    assign payload_start_o = out_ps_q;
    assign frame_done_o    = out_hs && out_last_q;
endmodule

// File: tb/tb_minn_preamble_inserter.sv
// Directed bench: preamble-only instance (a) and payload instance (b), NFFT=16, CP_LEN=4.
module tb_minn_preamble_inserter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        seq_wr_en_a = 1'b0, seq_wr_en_b = 1'b0;
    logic [1:0]  seq_wr_addr = '0;
    logic [11:0] seq_wr_i = '0, seq_wr_q = '0;
    logic        frame_req_a = 1'b0, frame_req_b = 1'b0;
    logic        rdy = 1'b1;
    logic        sel = 1'b0;
    logic        busy_a, busy_b, fs_a, fs_b, ps_a, ps_b, done_a, done_b;

    minn_preamble_inserter_if #(.SAMPLE_WIDTH(12)) in_a ();
    minn_preamble_inserter_if #(.SAMPLE_WIDTH(12)) out_a ();
    minn_preamble_inserter_if #(.SAMPLE_WIDTH(12)) in_b ();
    minn_preamble_inserter_if #(.SAMPLE_WIDTH(12)) out_b ();

    assign in_a.valid  = 1'b0;
    assign in_a.ch0_i  = '0;
    assign in_a.ch0_q  = '0;
    assign in_a.ch1_i  = '0;
    assign in_a.ch1_q  = '0;
    assign out_a.ready = rdy;
    assign out_b.ready = rdy;

    minn_preamble_inserter #(.SAMPLE_WIDTH(12), .NFFT(16), .CP_LEN(4), .PAYLOAD_LEN(0)) dut_a (
        .clk(clk), .rst(rst), .seq_wr_en_i(seq_wr_en_a), .seq_wr_addr_i(seq_wr_addr),
        .seq_wr_i_i(seq_wr_i), .seq_wr_q_i(seq_wr_q), .frame_req_i(frame_req_a), .busy_o(busy_a),
        .in_s(in_a), .out_m(out_a), .frame_start_o(fs_a), .payload_start_o(ps_a), .frame_done_o(done_a));

    minn_preamble_inserter #(.SAMPLE_WIDTH(12), .NFFT(16), .CP_LEN(4), .PAYLOAD_LEN(8)) dut_b (
        .clk(clk), .rst(rst), .seq_wr_en_i(seq_wr_en_b), .seq_wr_addr_i(seq_wr_addr),
        .seq_wr_i_i(seq_wr_i), .seq_wr_q_i(seq_wr_q), .frame_req_i(frame_req_b), .busy_o(busy_b),
        .in_s(in_b), .out_m(out_b), .frame_start_o(fs_b), .payload_start_o(ps_b), .frame_done_o(done_b));

    int   o_i0, o_q0, o_i1, o_q1;
    logic o_valid, o_fs, o_ps, o_done, o_busy;
    always_comb begin
        if (sel) begin
            o_valid = out_b.valid; o_fs = fs_b; o_ps = ps_b; o_done = done_b; o_busy = busy_b;
            o_i0 = int'(out_b.ch0_i); o_q0 = int'(out_b.ch0_q);
            o_i1 = int'(out_b.ch1_i); o_q1 = int'(out_b.ch1_q);
        end else begin
            o_valid = out_a.valid; o_fs = fs_a; o_ps = ps_a; o_done = done_a; o_busy = busy_a;
            o_i0 = int'(out_a.ch0_i); o_q0 = int'(out_a.ch0_q);
            o_i1 = int'(out_a.ch1_i); o_q1 = int'(out_a.ch1_q);
        end
    end

    int total = 0;
    int bad   = 0;
    int mi [2][4];
    int mq [2][4];
    int t1_i [20] = '{-1, -2, -3, -4, 1, 2, 3, 4, 1, 2, 3, 4, -1, -2, -3, -4, -1, -2, -3, -4};
    int cap_i0[$], cap_q0[$], cap_i1[$], cap_q1[$];
    bit cap_fs[$], cap_ps[$], cap_done[$];

    task automatic check(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint pack_out();
        return longint'({o_i0[11:0], o_q0[11:0], o_i1[11:0], o_q1[11:0], o_fs, o_ps});
    endfunction

    // Expected sample k of a frame: 4 CP, 16 symbol, then payload counters.
    function automatic int exp_sample(input int k, input bit is_q, input bit ch1, input bit which);
        int s, a, base;
        if (k >= 20) begin
            base = ch1 ? 200 : 100;
            return is_q ? -(base + k - 20) : base + k - 20;
        end
        s = (k < 4) ? 12 + k : k - 4;
        a = is_q ? mq[which][s % 4] : mi[which][s % 4];
        if (s / 4 >= 2) return (a == -2048) ? 2047 : -a;
        return a;
    endfunction

    task automatic set_req(input logic v);
        if (sel) frame_req_b = v;
        else     frame_req_a = v;
    endtask

    task automatic seq_write(input int addr, input int vi, input int vq);
        @(posedge clk); #1;
        seq_wr_addr = 2'(addr); seq_wr_i = 12'(vi); seq_wr_q = 12'(vq);
        seq_wr_en_a = 1'b1; seq_wr_en_b = 1'b1;
        mi[0][addr] = vi; mi[1][addr] = vi; mq[0][addr] = vq; mq[1][addr] = vq;
        @(posedge clk); #1;
        seq_wr_en_a = 1'b0; seq_wr_en_b = 1'b0;
    endtask

    task automatic collect(input string t, input int n, input bit rand_rdy, input bit feed,
                           input int req2_cyc, input int wr_cyc, input int wr_i, input int wr_q,
                           input bit req_at_done);
        int got, first_v, pay, dones;
        bit stalled;
        longint held;
        got = 0; first_v = -1; pay = 0; dones = 0; stalled = 1'b0; held = 0;
        cap_i0.delete(); cap_q0.delete(); cap_i1.delete(); cap_q1.delete();
        cap_fs.delete(); cap_ps.delete(); cap_done.delete();
        for (int cyc = 0; cyc < 400 && got < n; cyc++) begin
            @(posedge clk); #1;
            set_req(cyc == 0 || cyc == req2_cyc);
            seq_wr_en_a = 1'b0; seq_wr_en_b = 1'b0;
            if (cyc == wr_cyc) begin
                seq_wr_addr = 2'd0; seq_wr_i = 12'(wr_i); seq_wr_q = 12'(wr_q);
                if (sel) seq_wr_en_b = 1'b1;
                else     seq_wr_en_a = 1'b1;
            end
            rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            in_b.valid = feed && (cyc % 3 != 2);
            in_b.ch0_i = 12'(100 + pay);    in_b.ch0_q = 12'(-(100 + pay));
            in_b.ch1_i = 12'(200 + pay);    in_b.ch1_q = 12'(-(200 + pay));
            @(negedge clk);
            if (cyc == 1) check({t, "_busy_rise"}, o_busy, 1);
            if (stalled) begin
                check({t, "_stall_valid"}, o_valid, 1);
                check({t, "_stall_hold"}, pack_out(), held);
            end
            if (o_valid && first_v < 0) first_v = cyc;
            if (feed && in_b.valid && in_b.ready) pay++;
            stalled = o_valid && !rdy;
            held = pack_out();
            if (o_valid && rdy) begin
                cap_i0.push_back(o_i0); cap_q0.push_back(o_q0);
                cap_i1.push_back(o_i1); cap_q1.push_back(o_q1);
                cap_fs.push_back(o_fs); cap_ps.push_back(o_ps); cap_done.push_back(o_done);
                got++;
            end
            if (o_done) dones++;
            if (o_done && req_at_done) set_req(1'b1);
        end
        @(posedge clk); #1;
        set_req(1'b0);
        seq_wr_en_a = 1'b0; seq_wr_en_b = 1'b0;
        rdy = 1'b1;
        in_b.valid = feed;
        check({t, "_first_valid_within_3"}, (first_v >= 0 && first_v <= 3), 1);
        check({t, "_captured"}, got, n);
        check({t, "_done_pulses"}, dones, 1);
        if (feed) check({t, "_payload_consumed"}, pay, 8);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check({t, "_idle_valid"}, o_valid, 0);
            check({t, "_idle_busy"}, o_busy, 0);
            if (feed) check({t, "_idle_in_ready"}, in_b.ready, 0);
        end
        in_b.valid = 1'b0;
    endtask

    task automatic verify(input string t, input int n, input bit lit);
        int ei;
        for (int k = 0; k < n && k < cap_i0.size(); k++) begin
            ei = lit ? t1_i[k] : exp_sample(k, 1'b0, 1'b0, sel);
            check($sformatf("%s_ch0_i_%0d", t, k), cap_i0[k], ei);
            check($sformatf("%s_ch0_q_%0d", t, k), cap_q0[k], exp_sample(k, 1'b1, 1'b0, sel));
            check($sformatf("%s_ch1_i_%0d", t, k), cap_i1[k], lit ? ei : exp_sample(k, 1'b0, 1'b1, sel));
            check($sformatf("%s_ch1_q_%0d", t, k), cap_q1[k], exp_sample(k, 1'b1, 1'b1, sel));
            check($sformatf("%s_frame_start_%0d", t, k), cap_fs[k], k == 0);
            check($sformatf("%s_payload_start_%0d", t, k), cap_ps[k], (n > 20) && (k == 20));
            check($sformatf("%s_frame_done_%0d", t, k), cap_done[k], k == n - 1);
        end
    endtask

    initial begin
        in_b.valid = 1'b0;
        in_b.ch0_i = '0; in_b.ch0_q = '0; in_b.ch1_i = '0; in_b.ch1_q = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_valid_a", out_a.valid, 0);
        check("reset_valid_b", out_b.valid, 0);
        check("reset_busy_a", busy_a, 0);
        check("reset_busy_b", busy_b, 0);
        check("reset_in_ready_a", in_a.ready, 0);
        check("reset_in_ready_b", in_b.ready, 0);
        check("reset_markers", {fs_a, ps_a, done_a, fs_b, ps_b, done_b}, 0);
        check("reset_data_a", {out_a.ch0_i, out_a.ch0_q, out_a.ch1_i, out_a.ch1_q}, 0);

        seq_write(0, 1, 10);
        seq_write(1, 2, -20);
        seq_write(2, 3, 30);
        seq_write(3, 4, -40);

        // Preamble-only frame; a frame_req coinciding with frame_done must be ignored.
        sel = 1'b0;
        collect("t1", 20, 1'b0, 1'b0, -1, -1, 0, 0, 1'b1);
        verify("t1", 20, 1'b1);

        // Random backpressure, payload gaps, and ignored mid-frame request/write.
        sel = 1'b1;
        collect("t3", 28, 1'b1, 1'b1, 8, 8, 99, 99, 1'b0);
        verify("t3", 28, 1'b0);
        collect("t5", 28, 1'b0, 1'b1, -1, -1, 0, 0, 1'b0);
        verify("t5", 28, 1'b0);

        // Most-negative A[0], written in the same cycle the frame is requested.
        sel = 1'b0;
        collect("t2", 20, 1'b0, 1'b0, -1, 0, -2048, -2048, 1'b0);
        mi[0][0] = -2048; mq[0][0] = -2048;
        verify("t2", 20, 1'b0);

        // Reset during PRE aborts the frame; the next frame is complete.
        @(posedge clk); #1 frame_req_a = 1'b1;
        @(posedge clk); #1 frame_req_a = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("t6_valid_before_rst", out_a.valid, 1);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("t6_valid_after_rst", out_a.valid, 0);
            check("t6_busy_after_rst", busy_a, 0);
        end
        collect("t6", 20, 1'b0, 1'b0, -1, -1, 0, 0, 1'b0);
        verify("t6", 20, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
